// File: rtl/bram1_req_ctrl.sv
// bram1_req_ctrl: valid/ready request front end for a single-ported block RAM.
// Read data returns through a small in-order response FIFO. Admission uses
// credits, so a captured read always finds a free FIFO slot.
// Optional feature macro: BRAM1_REQ_CTRL_WRACK_EN. When defined, every write
// also returns a response (rsp_write=1, rsp_rdata=0), in order with reads.
module bram1_req_ctrl #(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1,
  parameter int PIPELINED  = 0,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_write,
  output logic                  bram_en,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_di,
  input  logic [DATA_WIDTH-1:0] bram_do
);

  localparam int LAT = 1 + PIPELINED;
  localparam int CW  = $clog2(RSP_DEPTH + 1);
  localparam int PW  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(RSP_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(RSP_DEPTH - 1);

  logic                  w_accept;
  logic                  w_respond;
  logic                  w_push;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_pushData;
  logic [CW-1:0]         w_inflight;
  logic [CW-1:0]         w_credits;

  logic [LAT-1:0]        r_tagValid;
  logic [DATA_WIDTH-1:0] r_fifoData [RSP_DEPTH];
  logic [PW-1:0]         r_wrPtr;
  logic [PW-1:0]         r_rdPtr;
  logic [CW-1:0]         r_count;

`ifdef BRAM1_REQ_CTRL_WRACK_EN
  logic [LAT-1:0]        r_tagWrite;
  logic [RSP_DEPTH-1:0]  r_fifoWrite;
  logic                  w_pushWrite;
`endif

  // Count responding requests still travelling through the RAM pipeline.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < LAT; i++) begin
      w_inflight = w_inflight + CW'(r_tagValid[i]);
    end
  end

  // Credits cover both FIFO occupancy and reads the RAM has yet to return,
  // so every tag that exits the pipeline is guaranteed a slot.
  assign w_credits = r_count + w_inflight;
  assign req_ready = RST_N & (w_credits < DEPTH_C);
  assign w_accept  = req_valid & req_ready;

`ifdef BRAM1_REQ_CTRL_WRACK_EN
  assign w_respond = w_accept;
`else
  assign w_respond = w_accept & ~req_write;
`endif

  assign bram_en   = w_accept;
  assign bram_we   = w_accept & req_write;
  assign bram_addr = req_addr;
  assign bram_di   = req_wdata;

  assign w_push    = r_tagValid[LAT-1];
  assign w_pop     = rsp_valid & rsp_ready;

`ifdef BRAM1_REQ_CTRL_WRACK_EN
  assign w_pushWrite = r_tagWrite[LAT-1];
  assign w_pushData  = w_pushWrite ? '0 : bram_do;
`else
  assign w_pushData  = bram_do;
`endif

  // Latency-matching tag pipeline: a tag reaches the last stage exactly when
  // the RAM's DO holds the data for that request.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_tagValid <= '0;
`ifdef BRAM1_REQ_CTRL_WRACK_EN
      r_tagWrite <= '0;
`endif
    end else begin
      r_tagValid[0] <= w_respond;
`ifdef BRAM1_REQ_CTRL_WRACK_EN
      r_tagWrite[0] <= w_respond & req_write;
`endif
      for (int i = 1; i < LAT; i++) begin
        r_tagValid[i] <= r_tagValid[i-1];
`ifdef BRAM1_REQ_CTRL_WRACK_EN
        r_tagWrite[i] <= r_tagWrite[i-1];
`endif
      end
    end
  end

  // FIFO storage needs no reset; the head is masked while the FIFO is empty.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_fifoData[r_wrPtr] <= w_pushData;
    end
  end

`ifdef BRAM1_REQ_CTRL_WRACK_EN
  // Write-ack flag per FIFO entry, cleared so a reset never exposes stale acks.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_fifoWrite <= '0;
    end else if (w_push) begin
      r_fifoWrite[r_wrPtr] <= w_pushWrite;
    end
  end
`endif

  // Pointers and occupancy; a simultaneous push and pop leaves the count alone.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= (r_wrPtr == LAST_PTR) ? '0 : r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= (r_rdPtr == LAST_PTR) ? '0 : r_rdPtr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rsp_valid = (r_count != '0);
  assign rsp_rdata = rsp_valid ? r_fifoData[r_rdPtr] : '0;
`ifdef BRAM1_REQ_CTRL_WRACK_EN
  assign rsp_write = rsp_valid & r_fifoWrite[r_rdPtr];
`else
  assign rsp_write = 1'b0;
`endif

`ifndef SYNTHESIS
  // A capture into a full FIFO without a matching pop means credits leaked.
  a_noOverflow: assert property (@(posedge CLK) disable iff (!RST_N)
    !(w_push && !w_pop && (r_count == DEPTH_C)));
`endif

endmodule

// File: tb/tb_bram1_req_ctrl.sv
// Directed testbench for bram1_req_ctrl with a behavioural pipelined RAM.
module tb_bram1_req_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int PIPE  = 1;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rstN;
  logic          reqValid;
  logic          reqReady;
  logic          reqWrite;
  logic [AW-1:0] reqAddr;
  logic [DW-1:0] reqWdata;
  logic          rspValid;
  logic          rspReady;
  logic [DW-1:0] rspRdata;
  logic          rspWrite;
  logic          bramEn;
  logic          bramWe;
  logic [AW-1:0] bramAddr;
  logic [DW-1:0] bramDi;
  logic [DW-1:0] bramDo;

  logic [DW-1:0] ramMem [16];
  logic [DW-1:0] ramDo1;
  logic [DW-1:0] ramDo2;
  logic [DW-1:0] expMem [16];

  int numChecks = 0;
  int numFails  = 0;

  always #5 clk = ~clk;

  bram1_req_ctrl #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .PIPELINED (PIPE),
    .RSP_DEPTH (DEPTH)
  ) dut (
    .CLK      (clk),
    .RST_N    (rstN),
    .req_valid(reqValid),
    .req_ready(reqReady),
    .req_write(reqWrite),
    .req_addr (reqAddr),
    .req_wdata(reqWdata),
    .rsp_valid(rspValid),
    .rsp_ready(rspReady),
    .rsp_rdata(rspRdata),
    .rsp_write(rspWrite),
    .bram_en  (bramEn),
    .bram_we  (bramWe),
    .bram_addr(bramAddr),
    .bram_di  (bramDi),
    .bram_do  (bramDo)
  );

  // Read-first single-port RAM with optional output register, no reset.
  always @(posedge clk) begin
    if (bramEn) begin
      if (bramWe) ramMem[bramAddr] <= bramDi;
      ramDo1 <= ramMem[bramAddr];
    end
    ramDo2 <= ramDo1;
  end
  assign bramDo = (PIPE != 0) ? ramDo2 : ramDo1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstN = 1'b0; reqValid = 1'b1; reqWrite = 1'b0; reqAddr = '0; reqWdata = '0; rspReady = 1'b0;
    #2;
    numChecks++; if (reqReady !== 1'b0) begin numFails++; $display("[TB] FAIL reset_ready: got %0b want 0", reqReady); end
    numChecks++; if (bramEn !== 1'b0) begin numFails++; $display("[TB] FAIL reset_en: got %0b want 0", bramEn); end
    numChecks++; if (rspValid !== 1'b0) begin numFails++; $display("[TB] FAIL reset_rspvalid: got %0b want 0", rspValid); end
    numChecks++; if (rspRdata !== '0 || rspWrite !== 1'b0) begin numFails++; $display("[TB] FAIL reset_rspdata: got %h/%0b want 0/0", rspRdata, rspWrite); end
    tick(); tick();
    reqValid = 1'b0;
    rstN = 1'b1;
    #1;
    numChecks++; if (reqReady !== 1'b1) begin numFails++; $display("[TB] FAIL reset_exit_ready: got %0b want 1", reqReady); end
    tick();
  endtask

  task automatic test_write_read();
    rspReady = 1'b1;
    reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 4'd5; reqWdata = 32'hDEADBEEF;
    expMem[5] = 32'hDEADBEEF;
    #1;
    numChecks++; if (bramEn !== 1'b1 || bramWe !== 1'b1) begin numFails++; $display("[TB] FAIL wr_pins: got en=%0b we=%0b want 1/1", bramEn, bramWe); end
    numChecks++; if (bramAddr !== 4'd5 || bramDi !== 32'hDEADBEEF) begin numFails++; $display("[TB] FAIL wr_passthru: got %0d/%h want 5/deadbeef", bramAddr, bramDi); end
    tick();
    reqWrite = 1'b0;
    #1;
    numChecks++; if (bramEn !== 1'b1 || bramWe !== 1'b0) begin numFails++; $display("[TB] FAIL rd_pins: got en=%0b we=%0b want 1/0", bramEn, bramWe); end
    tick();
    reqValid = 1'b0;
    #1;
    numChecks++; if (rspValid !== 1'b0) begin numFails++; $display("[TB] FAIL rd_early1: got %0b want 0", rspValid); end
    tick();
`ifdef BRAM1_REQ_CTRL_WRACK_EN
    numChecks++; if (rspValid !== 1'b1 || rspWrite !== 1'b1 || rspRdata !== '0) begin numFails++; $display("[TB] FAIL wr_ack: got v=%0b w=%0b d=%h want 1/1/0", rspValid, rspWrite, rspRdata); end
`else
    numChecks++; if (rspValid !== 1'b0) begin numFails++; $display("[TB] FAIL rd_early2: got %0b want 0", rspValid); end
`endif
    tick();
    numChecks++; if (rspValid !== 1'b1 || rspWrite !== 1'b0 || rspRdata !== 32'hDEADBEEF) begin numFails++; $display("[TB] FAIL rd_data: got v=%0b w=%0b d=%h want 1/0/deadbeef", rspValid, rspWrite, rspRdata); end
    tick();
    numChecks++; if (rspValid !== 1'b0) begin numFails++; $display("[TB] FAIL rd_drain: got %0b want 0", rspValid); end
  endtask

  task automatic test_backpressure();
    int issued = 0;
    int received = 0;
    logic accNow;
    logic popNow;
    rspReady = 1'b0; reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 4'd8;
    for (int c = 0; c < 8; c++) begin
      #1;
      accNow = reqValid & reqReady;
      tick();
      if (accNow) begin
        issued++;
        if (issued == 6) reqValid = 1'b0; else reqAddr = AW'(8 + issued);
      end
    end
    #1;
    numChecks++; if (issued != 4) begin numFails++; $display("[TB] FAIL bp_accepted: got %0d want 4", issued); end
    numChecks++; if (reqReady !== 1'b0) begin numFails++; $display("[TB] FAIL bp_ready_low: got %0b want 0", reqReady); end
    rspReady = 1'b1;
    for (int c = 0; c < 40 && (received < 6 || issued < 6); c++) begin
      #1;
      accNow = reqValid & reqReady;
      popNow = rspValid & rspReady;
      if (popNow) begin
        numChecks++;
        if (rspRdata !== expMem[8 + received] || rspWrite !== 1'b0) begin
          numFails++; $display("[TB] FAIL bp_data%0d: got %h want %h", received, rspRdata, expMem[8 + received]);
        end
        received++;
      end
      tick();
      if (accNow) begin
        issued++;
        if (issued == 6) reqValid = 1'b0; else reqAddr = AW'(8 + issued);
      end
    end
    reqValid = 1'b0;
    numChecks++; if (received != 6 || issued != 6) begin numFails++; $display("[TB] FAIL bp_totals: got rx=%0d tx=%0d want 6/6", received, issued); end
  endtask

  task automatic test_streaming();
    int issued = 0;
    int received = 0;
    int stalls = 0;
    logic accNow;
    rspReady = 1'b1; reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 4'd0;
    for (int c = 0; c < 40 && received < 16; c++) begin
      #1;
      if (reqValid && !reqReady) stalls++;
      accNow = reqValid & reqReady;
      if (rspValid) begin
        numChecks++;
        if (rspRdata !== expMem[received]) begin
          numFails++; $display("[TB] FAIL stream_data%0d: got %h want %h", received, rspRdata, expMem[received]);
        end
        received++;
      end
      tick();
      if (accNow) begin
        issued++;
        if (issued == 16) reqValid = 1'b0; else reqAddr = AW'(issued);
      end
    end
    reqValid = 1'b0;
    numChecks++; if (stalls != 0) begin numFails++; $display("[TB] FAIL stream_stalls: got %0d want 0", stalls); end
    numChecks++; if (received != 16) begin numFails++; $display("[TB] FAIL stream_count: got %0d want 16", received); end
  endtask

  task automatic test_push_pop_same_cycle();
    int stalls = 0;
    rspReady = 1'b0; reqWrite = 1'b0; reqValid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      reqAddr = AW'(k);
      #1;
      if (!reqReady) stalls++;
      tick();
    end
    reqValid = 1'b0;
    numChecks++; if (stalls != 0) begin numFails++; $display("[TB] FAIL pp_fill_stalls: got %0d want 0", stalls); end
    numChecks++; if (reqReady !== 1'b0 || rspValid !== 1'b1) begin numFails++; $display("[TB] FAIL pp_credit_full: got rdy=%0b v=%0b want 0/1", reqReady, rspValid); end
    tick();
    rspReady = 1'b1;
    numChecks++; if (rspRdata !== expMem[0]) begin numFails++; $display("[TB] FAIL pp_head0: got %h want %h", rspRdata, expMem[0]); end
    tick();
    numChecks++; if (reqReady !== 1'b1 || rspRdata !== expMem[1]) begin numFails++; $display("[TB] FAIL pp_after: got rdy=%0b d=%h want 1/%h", reqReady, rspRdata, expMem[1]); end
    tick();
    numChecks++; if (rspValid !== 1'b1 || rspRdata !== expMem[2]) begin numFails++; $display("[TB] FAIL pp_head2: got %h want %h", rspRdata, expMem[2]); end
    tick();
    numChecks++; if (rspValid !== 1'b1 || rspRdata !== expMem[3]) begin numFails++; $display("[TB] FAIL pp_head3: got %h want %h", rspRdata, expMem[3]); end
    tick();
    numChecks++; if (rspValid !== 1'b0) begin numFails++; $display("[TB] FAIL pp_empty: got %0b want 0", rspValid); end
  endtask

  task automatic test_write_ack();
    logic          kindWr [3];
    logic [AW-1:0] kindAddr [3];
    logic [DW-1:0] wantData [3];
    logic          wantWr [3];
    int nWant;
    int received = 0;
    kindWr[0] = 1'b0; kindAddr[0] = 4'd1;
    kindWr[1] = 1'b1; kindAddr[1] = 4'd2;
    kindWr[2] = 1'b0; kindAddr[2] = 4'd3;
    expMem[2] = 32'h12345678;
`ifdef BRAM1_REQ_CTRL_WRACK_EN
    nWant = 3;
    wantData[0] = expMem[1]; wantWr[0] = 1'b0;
    wantData[1] = '0;        wantWr[1] = 1'b1;
    wantData[2] = expMem[3]; wantWr[2] = 1'b0;
`else
    nWant = 2;
    wantData[0] = expMem[1]; wantWr[0] = 1'b0;
    wantData[1] = expMem[3]; wantWr[1] = 1'b0;
    wantData[2] = '0;        wantWr[2] = 1'b0;
`endif
    rspReady = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k < 3) begin
        reqValid = 1'b1; reqWrite = kindWr[k]; reqAddr = kindAddr[k]; reqWdata = 32'h12345678;
      end else begin
        reqValid = 1'b0;
      end
      #1;
      if (k < 3) begin
        numChecks++; if (reqReady !== 1'b1) begin numFails++; $display("[TB] FAIL wa_ready%0d: got %0b want 1", k, reqReady); end
      end
      if (rspValid) begin
        if (received < 3) begin
          numChecks++;
          if (rspRdata !== wantData[received] || rspWrite !== wantWr[received]) begin
            numFails++; $display("[TB] FAIL wa_rsp%0d: got %h/%0b want %h/%0b", received, rspRdata, rspWrite, wantData[received], wantWr[received]);
          end
        end
        received++;
      end
      tick();
    end
    numChecks++; if (received != nWant) begin numFails++; $display("[TB] FAIL wa_count: got %0d want %0d", received, nWant); end
  endtask

  task automatic test_reset_midop();
    int stale = 0;
    int waited = 0;
    rspReady = 1'b0; reqWrite = 1'b0; reqValid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      reqAddr = AW'(4 + k);
      tick();
    end
    reqValid = 1'b0;
    #1;
    numChecks++; if (rspValid !== 1'b1) begin numFails++; $display("[TB] FAIL rm_setup: got %0b want 1", rspValid); end
    rstN = 1'b0;
    reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 4'd5; reqWdata = 32'hFFFFFFFF;
    #1;
    numChecks++; if (rspValid !== 1'b0 || reqReady !== 1'b0) begin numFails++; $display("[TB] FAIL rm_in_reset: got v=%0b rdy=%0b want 0/0", rspValid, reqReady); end
    numChecks++; if (bramEn !== 1'b0 || rspRdata !== '0) begin numFails++; $display("[TB] FAIL rm_outputs: got en=%0b d=%h want 0/0", bramEn, rspRdata); end
    tick(); tick();
    reqValid = 1'b0; reqWrite = 1'b0;
    rstN = 1'b1;
    #1;
    numChecks++; if (reqReady !== 1'b1 || rspValid !== 1'b0) begin numFails++; $display("[TB] FAIL rm_release: got rdy=%0b v=%0b want 1/0", reqReady, rspValid); end
    rspReady = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (rspValid) stale++;
    end
    numChecks++; if (stale != 0) begin numFails++; $display("[TB] FAIL rm_stale: got %0d want 0", stale); end
    reqValid = 1'b1; reqAddr = 4'd5;
    tick();
    reqValid = 1'b0;
    while (!rspValid && waited < 10) begin
      tick();
      waited++;
    end
    numChecks++; if (rspValid !== 1'b1 || rspRdata !== expMem[5]) begin numFails++; $display("[TB] FAIL rm_ram_kept: got v=%0b d=%h want 1/%h", rspValid, rspRdata, expMem[5]); end
    tick();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      ramMem[i] = DW'(i * 3);
      expMem[i] = DW'(i * 3);
    end
    test_reset();
    test_write_read();
    test_backpressure();
    test_streaming();
    test_push_pop_same_cycle();
    test_write_ack();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
